// File: rtl/regfile_wb_sequencer.sv
// ============================================================================
// Module   : regfile_wb_sequencer
// Purpose  : Serialises write-back requests onto the single register-file
//            write port. A long (UMULL/SMULL) request becomes two writes.
//            Optional macro WB_BYPASS_EN adds a same-cycle forwarding probe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_sequencer #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 4,
    parameter logic [ADDR_W-1:0] PC_ADDR = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_long,
    input  logic [ADDR_W-1:0] req_wa3,
    input  logic [ADDR_W-1:0] req_wa4,
    input  logic [DATA_W-1:0] req_lo,
    input  logic [DATA_W-1:0] req_hi,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              pc_wr,
    output logic              done,
    output logic              err_same_dst
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] byp_addr,
    output logic              byp_hit,
    output logic [DATA_W-1:0] byp_data
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                long_q, long_d;
    logic [ADDR_W-1:0]   wa3_q, wa3_d;
    logic [ADDR_W-1:0]   wa4_q, wa4_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0]   rf_wd_q, rf_wd_d;
    logic                pc_wr_q, pc_wr_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;

    // Ready in every final write cycle so back-to-back requests stream.
    assign req_ready = (state_q == ST_IDLE) ||
                       (state_q == ST_WR_LO && !long_q) ||
                       (state_q == ST_WR_HI);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        long_d  = long_q;
        wa3_d   = wa3_q;
        wa4_d   = wa4_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        rf_we_d = 1'b0;
        rf_wa_d = '0;
        rf_wd_d = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pc_wr_d = 1'b0;

        unique case (state_q)
            ST_IDLE:  state_d = accept ? ST_WR_LO : ST_IDLE;
            ST_WR_LO: begin
                if (long_q)      state_d = ST_WR_HI;
                else if (accept) state_d = ST_WR_LO;
                else             state_d = ST_IDLE;
            end
            ST_WR_HI: state_d = accept ? ST_WR_LO : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (accept) begin
            long_d = req_long;
            wa3_d  = req_wa3;
            wa4_d  = req_wa4;
            lo_d   = req_lo;
            hi_d   = req_hi;
        end

        // Outputs are decoded from the next state so they appear registered.
        if (state_d == ST_WR_LO) begin
            rf_we_d = 1'b1;
            rf_wa_d = wa3_d;
            rf_wd_d = lo_d;
            done_d  = !long_d;
            err_d   = long_d && (wa3_d == wa4_d);
        end else if (state_d == ST_WR_HI) begin
            rf_we_d = 1'b1;
            rf_wa_d = wa4_d;
            rf_wd_d = hi_d;
            done_d  = 1'b1;
        end
        pc_wr_d = rf_we_d && (rf_wa_d == PC_ADDR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            long_q  <= 1'b0;
            wa3_q   <= '0;
            wa4_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
            pc_wr_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            long_q  <= long_d;
            wa3_q   <= wa3_d;
            wa4_q   <= wa4_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
            pc_wr_q <= pc_wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_wa        = rf_wa_q;
    assign rf_wd        = rf_wd_q;
    assign pc_wr        = pc_wr_q;
    assign done         = done_q;
    assign err_same_dst = err_q;

`ifdef WB_BYPASS_EN
    assign byp_hit  = rf_we_q && (rf_wa_q == byp_addr);
    assign byp_data = byp_hit ? rf_wd_q : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_sequencer.sv
// ============================================================================
// Module   : tb_regfile_wb_sequencer
// Purpose  : Scoreboard bench for regfile_wb_sequencer; expected writes are
//            queued at issue and popped by a monitor on every rf_we cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_long = 1'b0;
    logic [3:0]  req_wa3 = '0;
    logic [3:0]  req_wa4 = '0;
    logic [31:0] req_lo = '0;
    logic [31:0] req_hi = '0;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        pc_wr;
    logic        done;
    logic        err_same_dst;
`ifdef WB_BYPASS_EN
    logic [3:0]  byp_addr = '0;
    logic        byp_hit;
    logic [31:0] byp_data;
`endif

    regfile_wb_sequencer #(.DATA_W(32), .ADDR_W(4), .PC_ADDR(4'hF)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_long     (req_long),
        .req_wa3      (req_wa3),
        .req_wa4      (req_wa4),
        .req_lo       (req_lo),
        .req_hi       (req_hi),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .pc_wr        (pc_wr),
        .done         (done),
        .err_same_dst (err_same_dst)
`ifdef WB_BYPASS_EN
        ,
        .byp_addr     (byp_addr),
        .byp_hit      (byp_hit),
        .byp_data     (byp_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        done;
        logic        pc;
        logic        err;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [3:0] wa, input logic [31:0] wd,
                             input logic dn, input logic pc, input logic er);
        exp_q.push_back('{wa: wa, wd: wd, done: dn, pc: pc, err: er});
    endtask

    // Drive a request and hold it until accepted; returns cycles waited.
    task automatic send(input logic lng, input logic [3:0] a3, input logic [3:0] a4,
                        input logic [31:0] lo, input logic [31:0] hi, output int waited);
        @(negedge clk);
        req_valid = 1'b1;
        req_long  = lng;
        req_wa3   = a3;
        req_wa4   = a4;
        req_lo    = lo;
        req_hi    = hi;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: req_ready stayed %b, expected 1", req_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_long  = 1'b0;
        req_wa3   = 4'h0;
        req_wa4   = 4'h0;
        req_lo    = 32'hDEAD_DEAD;
        req_hi    = 32'hBEEF_BEEF;
    endtask

    // Monitor: every write must match the head of the scoreboard; idle cycles must be all-zero.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got wa=%h wd=%h done=%b, expected no write",
                         rf_wa, rf_wd, done);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rf_wa, rf_wd, done, pc_wr, err_same_dst} !== mon_e) begin
                    n_err++;
                    $display("FAIL write: got wa=%h wd=%h done=%b pc=%b err=%b expected wa=%h wd=%h done=%b pc=%b err=%b",
                             rf_wa, rf_wd, done, pc_wr, err_same_dst,
                             mon_e.wa, mon_e.wd, mon_e.done, mon_e.pc, mon_e.err);
                end
            end
        end else begin
            n_cmp++;
            if ({rf_we, rf_wa, rf_wd, done, pc_wr, err_same_dst} !== '0) begin
                n_err++;
                $display("FAIL idle_outputs: got we=%b wa=%h wd=%h done=%b pc=%b err=%b expected all 0",
                         rf_we, rf_wa, rf_wd, done, pc_wr, err_same_dst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'd1);
        check("reset_we", 64'(rf_we), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        #1 reset = 1'b1;
        @(negedge clk);
        check("ready_after_release", 64'(req_ready), 64'd1);

        // Single short write
        expect_wr(4'h3, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        send(1'b0, 4'h3, 4'h0, 32'h1234_5678, 32'h0, w);
        idle();
        @(negedge clk);
        check("short_we_cleared", 64'(rf_we), 64'd0);

        // Long write: ready drops during WR_LO
        expect_wr(4'h2, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
        expect_wr(4'h5, 32'h0000_BBBB, 1'b1, 1'b0, 1'b0);
        send(1'b1, 4'h2, 4'h5, 32'hAAAA_0001, 32'h0000_BBBB, w);
        idle();
        check("long_ready_low", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("long_ready_hi", 64'(req_ready), 64'd1);
        repeat (2) @(negedge clk);

        // Three back-to-back shorts with valid held
        expect_wr(4'h1, 32'h0000_0011, 1'b1, 1'b0, 1'b0);
        expect_wr(4'h6, 32'h0000_0022, 1'b1, 1'b0, 1'b0);
        expect_wr(4'h9, 32'h0000_0033, 1'b1, 1'b0, 1'b0);
        send(1'b0, 4'h1, 4'h0, 32'h0000_0011, 32'h0, w);
        check("b2b_wait0", 64'(w), 64'd0);
        send(1'b0, 4'h6, 4'h0, 32'h0000_0022, 32'h0, w);
        check("b2b_wait1", 64'(w), 64'd0);
        send(1'b0, 4'h9, 4'h0, 32'h0000_0033, 32'h0, w);
        check("b2b_wait2", 64'(w), 64'd0);
        idle();
        check("b2b_ready_end", 64'(req_ready), 64'd1);
        repeat (2) @(negedge clk);

        // PC writes: short to R15, then long with RdHi = R15
        expect_wr(4'hF, 32'h0000_1000, 1'b1, 1'b1, 1'b0);
        send(1'b0, 4'hF, 4'h0, 32'h0000_1000, 32'h0, w);
        expect_wr(4'h1, 32'h5555_0000, 1'b0, 1'b0, 1'b0);
        expect_wr(4'hF, 32'h0000_2000, 1'b1, 1'b1, 1'b0);
        send(1'b1, 4'h1, 4'hF, 32'h5555_0000, 32'h0000_2000, w);
        check("pc_long_no_wait", 64'(w), 64'd0);
        idle();
        repeat (3) @(negedge clk);

        // Long with RdLo == RdHi: error pulse on WR_LO, hi lands last
        expect_wr(4'h7, 32'h0BAD_0007, 1'b0, 1'b0, 1'b1);
        expect_wr(4'h7, 32'h600D_0007, 1'b1, 1'b0, 1'b0);
        send(1'b1, 4'h7, 4'h7, 32'h0BAD_0007, 32'h600D_0007, w);
        idle();
        repeat (3) @(negedge clk);

        // Reset during WR_LO of a long request discards the WR_HI write
`ifdef WB_BYPASS_EN
        byp_addr = 4'h2;
`endif
        expect_wr(4'h2, 32'hC0DE_0002, 1'b0, 1'b0, 1'b0);
        send(1'b1, 4'h2, 4'h4, 32'hC0DE_0002, 32'hFFFF_0004, w);
        idle();
`ifdef WB_BYPASS_EN
        #1;
        check("byp_hit", 64'(byp_hit), 64'd1);
        check("byp_data", 64'(byp_data), 64'hC0DE_0002);
`endif
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_reset_we", 64'(rf_we), 64'd0);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("ready_after_mid_reset", 64'(req_ready), 64'd1);
        check("mid_reset_no_done", 64'(done), 64'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_wb_sequencer.md
Name: regfile_wb_sequencer

Overview:
- Write-back end of the register addressing path for the multi-cycle core.
- Takes one write-back request carrying the decoded destinations: WA3 (Rd / RdLo) and WA4 (RdHi), plus result data.
- Serializes the request onto the register file's single write port: one write for ordinary ops, two consecutive writes for UMULL/SMULL.
- Also flags writes to the PC and illegal RdLo==RdHi long multiplies.

Parameters:
- DATA_W, 32, width of one register write
- ADDR_W, 4, register address width
- PC_ADDR, 4'hF, register index treated as the PC

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- req_valid  in  1  write-back request present
- req_ready  out  1  sequencer can accept a request this cycle
- req_long  in  1  1 = 64-bit result (UMULL/SMULL), two writes
- req_wa3  in  ADDR_W  RdLo / Rd destination
- req_wa4  in  ADDR_W  RdHi destination (used only when req_long)
- req_lo  in  DATA_W  low word / single result
- req_hi  in  DATA_W  high word (used only when req_long)
- rf_we  out  1  register file write enable
- rf_wa  out  ADDR_W  register file write address
- rf_wd  out  DATA_W  register file write data
- pc_wr  out  1  current write targets PC_ADDR
- done  out  1  pulse on the final write cycle of a request
- err_same_dst  out  1  pulse: long request with req_wa3 == req_wa4
- byp_addr  in  ADDR_W  bypass probe address (WB_BYPASS_EN only)
- byp_hit  out  1  probe matches a write in flight (WB_BYPASS_EN only)
- byp_data  out  DATA_W  forwarded data (WB_BYPASS_EN only)

Behaviour:
- Reset asserted (low): state = IDLE; captured request cleared. All outputs 0 except req_ready.
- req_ready is 1 after reset is released.
- States:
  - IDLE: no write in progress.
  - WR_LO: rf_we=1, rf_wa=wa3, rf_wd=lo.
  - WR_HI: rf_we=1, rf_wa=wa4, rf_wd=hi.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. All req_* fields are registered on acceptance. The inputs may change freely after that edge.
- Transitions:
  - IDLE -> WR_LO on accept.
  - WR_LO -> WR_HI if the captured long = 1.
  - WR_LO (short) or WR_HI -> WR_LO if a new request is accepted in that cycle, else -> IDLE.
- req_ready = (state==IDLE) || (state==WR_LO && !long) || (state==WR_HI). Accepting during the final write cycle gives back-to-back throughput:
  - 1 write/cycle for short requests.
  - 2 cycles per long request.
- Latency: the first write appears in the cycle after acceptance. A long request completes 2 cycles after acceptance.
- done is 1 exactly in the final write cycle: WR_LO when short, WR_HI when long.
- pc_wr = rf_we && (rf_wa == PC_ADDR), in the same cycle as the write.
- err_same_dst: 1-cycle pulse in WR_LO when long && wa3==wa4. Both writes still occur; the RdHi write lands last and wins.
- rf_we = 0 in IDLE. rf_wa and rf_wd are 0 in IDLE, not held.
- Reset mid-operation: the pending write (including an unissued WR_HI) is discarded, with no partial completion and no done.
- Outputs are registered (state-decoded from flops); no combinational path from req_* to rf_*.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: byp_addr, byp_hit and byp_data exist and are combinational from the current state and byp_addr.
  - byp_hit = rf_we && (rf_wa == byp_addr).
  - byp_data = rf_wd when hit, else 0.
  - Lets the read stage forward a value being written this cycle.
- Not defined: those three ports and their logic are absent. Readers must wait one cycle for the register file.

Test Plan:
- Reset release, then short request (wa3=4'h3, lo=32'h1234_5678), valid for 1 cycle:
  - Next cycle: rf_we=1, rf_wa=3, rf_wd=32'h1234_5678, done=1.
  - Cycle after: rf_we=0.
- Long request (wa3=2, wa4=5, lo=32'hAAAA_0001, hi=32'h0000_BBBB):
  - Cycle+1: write R2 = AAAA_0001, req_ready=0.
  - Cycle+2: write R5 = 0000_BBBB, done=1.
- Three back-to-back short requests, valid held:
  - Writes on 3 consecutive cycles.
  - req_ready stays 1 throughout; done=1 each cycle.
- Short request with wa3=4'hF: pc_wr=1 in the write cycle only. Long request with wa4=4'hF: pc_wr=1 only in the WR_HI cycle.
- Long request with wa3=wa4=7: err_same_dst pulses in the WR_LO cycle; the final write to R7 = hi.
- Reset pulsed low during WR_LO of a long request: no WR_HI write, done never asserts, req_ready=1 after release. With WB_BYPASS_EN, byp_addr=2 during the R2 write gives byp_hit=1 and byp_data=lo.
